icache_ctrl: RTL

Direct-mapped instruction cache that answers the fetch stage's fetch-address / data-valid interface. Lookup is combinational: a hit returns the 64-bit line in the same cycle. A miss issues one tagged load on the instruction-memory bus, waits for the matching tag, and fills the line. The block sits between the fetch stage and the memory bus arbiter.

---
 rtl/icache_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache: zero-latency combinational hit lookup in front of a
// tagged instruction-memory bus, with one outstanding line fill at a time.
module icache_ctrl #(
  parameter int XLEN         = 32,
  parameter int NUM_LINES    = 32,
  parameter int MEM_TAG_BITS = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [XLEN-1:0]         proc2Icache_addr,
  output logic [63:0]             Icache2proc_data,
  output logic                    Icache2proc_data_valid,
  output logic [1:0]              proc2Imem_command,
  output logic [XLEN-1:0]         proc2Imem_addr,
  input  logic [MEM_TAG_BITS-1:0] Imem2proc_response,
  input  logic [63:0]             Imem2proc_data,
  input  logic [MEM_TAG_BITS-1:0] Imem2proc_tag,
  output logic                    miss_pending_debug
);

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = XLEN - 3 - IDX_BITS;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [NUM_LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0]     r_tags [NUM_LINES];
  logic [63:0]             r_data [NUM_LINES];

  logic [MEM_TAG_BITS-1:0] r_pend_tag;
  logic [IDX_BITS-1:0]     r_pend_index;
  logic [TAG_BITS-1:0]     r_pend_addr_tag;

  logic [IDX_BITS-1:0]     w_index;
  logic [TAG_BITS-1:0]     w_tag;
  logic [XLEN-1:0]         w_line_addr;
  logic                    w_hit;
  logic                    w_accept;
  logic                    w_fill;

  assign w_index     = proc2Icache_addr[3 +: IDX_BITS];
  assign w_tag       = proc2Icache_addr[XLEN-1 -: TAG_BITS];
  assign w_line_addr = proc2Icache_addr & ~(XLEN'(7));

  assign w_hit    = r_valid[w_index] && (r_tags[w_index] == w_tag);
  assign w_accept = (r_state == S_IDLE) && !w_hit && (Imem2proc_response != '0);
  // Tag 0 means "no transaction", so it must never match a pending load.
  assign w_fill   = (r_state == S_WAIT) && (Imem2proc_tag != '0) &&
                    (Imem2proc_tag == r_pend_tag);

  assign Icache2proc_data_valid = w_hit;
  assign Icache2proc_data       = w_hit ? r_data[w_index] : 64'h0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_WAIT;
      S_WAIT: if (w_fill)   w_next_state = S_IDLE;
      default:              w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    proc2Imem_command  = BUS_NONE;
    proc2Imem_addr     = '0;
    miss_pending_debug = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_hit) begin
          proc2Imem_command = BUS_LOAD;
          proc2Imem_addr    = w_line_addr;
        end
      end
      S_WAIT: miss_pending_debug = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_pend_tag      <= Imem2proc_response;
      r_pend_index    <= w_index;
      r_pend_addr_tag <= w_tag;
    end
  end

  // Valid bits are the only storage that needs reset; tag/data are qualified by them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[r_pend_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_fill) begin
      r_tags[r_pend_index] <= r_pend_addr_tag;
      r_data[r_pend_index] <= Imem2proc_data;
    end
  end

endmodule
